// File: rtl/qkd_transmitter_pulse_module.sv
// BB84 transmit pulse generator: buffers (bit, basis) symbols and fires one
// fixed-width one-hot laser trigger at the start of each time slot.
module qkd_transmitter_pulse_module #(
    parameter int SLOT_PERIOD = 16,
    parameter int PULSE_WIDTH = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_bit,
    input  logic                          in_basis,
    output logic [3:0]                    ttl_pulses,
    output logic                          pulse_active,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   photon_count,
    output logic [15:0]                   miss_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(SLOT_PERIOD);

    typedef logic [AW:0]   level_t;
    typedef logic [CW-1:0] cnt_t;
    typedef enum logic {IDLE, RUN} state_t;

    localparam level_t FULL_LEVEL = level_t'(FIFO_DEPTH);
    localparam cnt_t   LAST_SLOT  = cnt_t'(SLOT_PERIOD - 1);
    localparam cnt_t   PULSE_END  = cnt_t'(PULSE_WIDTH);

    state_t        state;
    cnt_t          slot_cnt;
    logic [1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [3:0]    code_q;
    logic [3:0]    head_code;
    logic [3:0]    ttl_next;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          slot_start;

    assign full       = (fifo_level == FULL_LEVEL);
    assign empty      = (fifo_level == '0);
    assign in_ready   = !full;
    assign push       = in_valid && !full;
    assign slot_start = (state == RUN) && (slot_cnt == '0);
    assign pop        = slot_start && !empty;

    // Channel index is {basis, bit}, so H/V/D/A map to bits 0..3.
    always_comb begin
        head_code = 4'b0001 << mem[rd_ptr];
    end

    // The pulse register is loaded one cycle ahead so the trigger is high
    // exactly on slot_cnt 1..PULSE_WIDTH.
    always_comb begin
        ttl_next = 4'b0000;
        if (slot_start) begin
            ttl_next = empty ? 4'b0000 : head_code;
        end else if (state == RUN && slot_cnt < PULSE_END) begin
            ttl_next = code_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_basis, in_bit};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            slot_cnt     <= '0;
            code_q       <= '0;
            ttl_pulses   <= '0;
            pulse_active <= 1'b0;
            photon_count <= '0;
            miss_count   <= '0;
        end else begin
            ttl_pulses   <= ttl_next;
            pulse_active <= |ttl_next;
            case (state)
                IDLE: begin
                    slot_cnt <= '0;
                    if (enable) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Stopping is only honoured at the slot boundary.
                    if (slot_cnt == LAST_SLOT) begin
                        slot_cnt <= '0;
                        if (!enable) begin
                            state <= IDLE;
                        end
                    end else begin
                        slot_cnt <= slot_cnt + 1'b1;
                    end
                    if (slot_cnt == '0) begin
                        if (!empty) begin
                            code_q       <= head_code;
                            photon_count <= photon_count + 16'd1;
                        end else begin
                            code_q <= '0;
                            if (miss_count != 16'hFFFF) begin
                                miss_count <= miss_count + 16'd1;
                            end
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    slot_cnt <= '0;
                end
            endcase
        end
    end

endmodule
